// File: rtl/bus_timer_irq.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer_irq
// Description : Memory-mapped 16-bit interval timer with prescaler and an
//               active-low interrupt request for the CPU core.
// Revision    : 1.0  initial release
// ============================================================================
module bus_timer_irq #(
    parameter logic [15:0] BASE = 16'hD000,
    parameter int unsigned PS_W = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        hit,
    output logic        irq_n
);

    localparam logic [2:0] C_LATCH_LO = 3'd0;
    localparam logic [2:0] C_LATCH_HI = 3'd1;
    localparam logic [2:0] C_CNT_LO   = 3'd2;
    localparam logic [2:0] C_CNT_HI   = 3'd3;
    localparam logic [2:0] C_CTRL     = 3'd4;
    localparam logic [2:0] C_STATUS   = 3'd5;
    localparam logic [2:0] C_PRESC    = 3'd6;

    logic [15:0]     latch_q, latch_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [7:0]      shadow_q, shadow_d;
    logic            en_q, en_d;
    logic            ie_q, ie_d;
    logic            oneshot_q, oneshot_d;
    logic            if_q, if_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            hit_q, hit_d;
    logic            irq_n_q, irq_n_d;

    logic       w_sel;
    logic [2:0] w_off;
    logic       w_wr;
    logic       w_tick;
    logic       w_load;

    assign w_sel  = (address[15:3] == BASE[15:3]);
    assign w_off  = address[2:0];
    assign w_wr   = w_sel & we;
    assign w_tick = en_q & (ps_q == presc_q);
    assign w_load = w_wr & (w_off == C_LATCH_HI);

    always_comb begin
        latch_d   = latch_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        en_d      = en_q;
        ie_d      = ie_q;
        oneshot_d = oneshot_q;
        if_d      = if_q;
        presc_d   = presc_q;
        ps_d      = ps_q;
        rdata_d   = 8'h00;
        hit_d     = w_sel;
        irq_n_d   = ~(if_q & ie_q);

        // Read data reflects pre-write register state for this cycle.
        if (w_sel) begin
            case (w_off)
                C_LATCH_LO: rdata_d = latch_q[7:0];
                C_LATCH_HI: rdata_d = latch_q[15:8];
                C_CNT_LO:   rdata_d = cnt_q[7:0];
                C_CNT_HI:   rdata_d = shadow_q;
                C_CTRL:     rdata_d = {5'b00000, oneshot_q, ie_q, en_q};
                C_STATUS:   rdata_d = {7'b0000000, if_q};
                C_PRESC:    rdata_d = 8'(presc_q);
                default:    rdata_d = 8'h00;
            endcase
        end

        if (w_sel && !we && (w_off == C_CNT_LO)) begin
            shadow_d = cnt_q[15:8];
        end

        if (en_q) begin
            ps_d = w_tick ? '0 : ps_q + PS_W'(1);
        end

        if (w_wr) begin
            case (w_off)
                C_LATCH_LO: latch_d[7:0] = wdata;
                C_LATCH_HI: begin
                    latch_d[15:8] = wdata;
                    cnt_d         = {wdata, latch_q[7:0]};
                    ps_d          = '0;
                end
                C_CTRL: begin
                    en_d      = wdata[0];
                    ie_d      = wdata[1];
                    oneshot_d = wdata[2];
                    if (!en_q && wdata[0]) begin
                        ps_d = '0;
                    end
                end
                C_STATUS: begin
                    if (wdata[0]) begin
                        if_d = 1'b0;
                    end
                end
                C_PRESC:  presc_d = wdata[PS_W-1:0];
                default:  ;
            endcase
        end

        // Underflow is evaluated last so its flag set and EN clear win.
        if (w_tick && !w_load) begin
            if (cnt_q != 16'h0000) begin
                cnt_d = cnt_q - 16'd1;
            end else begin
                if_d = 1'b1;
                if (oneshot_q) begin
                    en_d = 1'b0;
                end else begin
                    cnt_d = latch_q;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latch_q   <= 16'h0000;
            cnt_q     <= 16'h0000;
            shadow_q  <= 8'h00;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            oneshot_q <= 1'b0;
            if_q      <= 1'b0;
            presc_q   <= '0;
            ps_q      <= '0;
            rdata_q   <= 8'h00;
            hit_q     <= 1'b0;
            irq_n_q   <= 1'b1;
        end else begin
            latch_q   <= latch_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            oneshot_q <= oneshot_d;
            if_q      <= if_d;
            presc_q   <= presc_d;
            ps_q      <= ps_d;
            rdata_q   <= rdata_d;
            hit_q     <= hit_d;
            irq_n_q   <= irq_n_d;
        end
    end

    assign rdata = rdata_q;
    assign hit   = hit_q;
    assign irq_n = irq_n_q;

endmodule
`default_nettype wire
